wb_bypass_regfile: RTL and testbench
====================================

Name: wb_bypass_regfile

Overview:
- Parametrised register file for the pipelined MIPS core: NRD combinational read ports, one write-back port, write-through bypass.
- Generalises the WB forwarding unit by owning the register array itself (width, depth and port count are parameters).
- Adds a per-register pending-write scoreboard: issue-time reservation, write-back release, read-valid and stall outputs for the ID stage.

Parameters:
DW, 32, data width in bits
NREGS, 32, number of architectural registers (power of two)
AW, 5, address width, equals log2(NREGS)
NRD, 2, number of read ports
PEND_W, 2, width of each per-register pending counter (max 2^PEND_W-1 outstanding writes)

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
rd_addr  input  NRD*AW  read addresses; port i at [i*AW +: AW]
rd_data  output  NRD*DW  read data; port i at [i*DW +: DW]
rd_valid  output  NRD  port i data is architecturally current
stall  output  1  OR of ~rd_valid over ports with rd_en set
rd_en  input  NRD  port i is actually used by the ID-stage instruction
wr_en  input  1  write-back valid (RegWrite)
wr_addr  input  AW  write-back destination
wr_data  input  DW  write-back data
iss_en  input  1  instruction with a destination leaves ID this cycle
iss_addr  input  AW  destination reserved at issue
pend_err  output  1  sticky: pending-counter overflow or underflow

Behaviour:
- Reset (reset_n low, asynchronous): all array entries 0, all pending counters 0, pend_err 0. Combinational outputs follow: rd_data 0, rd_valid all 1, stall 0.
- Register 0 is hardwired zero:
  - reads of address 0 return 0 with rd_valid 1;
  - writes, issues and write-backs to address 0 are ignored and never touch counters or pend_err.
- Write: on the rising edge, if wr_en and wr_addr!=0, the array entry wr_addr takes wr_data.
- Read is combinational, zero latency. For each port i:
  - bypass: if wr_en and wr_addr==rd_addr[i]!=0, rd_data[i]=wr_data;
  - otherwise rd_data[i]=array[rd_addr[i]].
- Scoreboard, per register r!=0, updated on the rising edge:
  - inc = iss_en & iss_addr==r; dec = wr_en & wr_addr==r;
  - inc&~dec: cnt+1; dec&~inc: cnt-1; both or neither: unchanged.
  - Overflow (inc, no dec, cnt at all ones): cnt holds, pend_err set.
  - Underflow (dec, no inc, cnt 0): cnt holds at 0, pend_err set. The write itself still happens.
  - pend_err clears only on reset.
- rd_valid[i]:
  - 1 when rd_addr[i]==0;
  - else 1 when cnt[rd_addr[i]]==0;
  - else 1 when cnt==1 and the bypass hit is active this cycle (last outstanding write arriving now);
  - else 0.
- stall = |(rd_en & ~rd_valid). While stall is high the ID stage must hold iss_en low; the block does not enforce this.
- Combinational paths exist from rd_addr, wr_* to rd_data, rd_valid and stall. There is no path from iss_* to any output in the same cycle.
- Reset mid-operation: all reservations are lost, so the pipeline must be flushed together with this block.

Optional Feature:
- Macro: WB_BYPASS_PERF_EN.
- Defined: adds outputs perf_bypass[31:0] and perf_stall[31:0], both reset to 0.
  - perf_bypass increments once per cycle in which at least one port with rd_en set takes the bypass path.
  - perf_stall increments per cycle with stall high.
  - Both saturate at 32'hFFFF_FFFF.
- Not defined: neither port nor counter exists; the rest of the behaviour is identical.

Decomposition:
- Shared package wb_bypass_pkg: default DW/AW/NREGS constants, ZERO_REG=0, and a pend_cnt_t typedef sized by PEND_W.
- One natural sub-module, wb_bypass_rdport: per-port bypass mux plus valid logic, instantiated NRD times in a generate loop.
- Array and scoreboard stay in the top module.

Test Plan:
- Reset, then read both ports at addresses 3 and 0 -> rd_data 0, rd_valid 2'b11, stall 0, pend_err 0.
- Write r5=32'hDEAD_BEEF; next cycle read port0 at r5 -> 32'hDEAD_BEEF. Same-cycle read during the write -> bypass also returns 32'hDEAD_BEEF.
- Issue r7 at cycle 0; at cycle 1 read r7 with rd_en=1 -> rd_valid 0, stall 1. At cycle 3 write-back r7=32'h1234 while reading -> rd_valid 1, rd_data 32'h1234, stall 0.
- Issue r9 twice (cnt=2). The first write-back of 32'h11 leaves rd_valid 0. The second write-back of 32'h22 gives valid 1 with data 32'h22.
- In the same cycle, issue r4 and write back r4 with cnt=1 -> cnt stays 1, rd_valid 0 next cycle. Write-back to r6 with cnt=0 -> pend_err 1, persisting until reset.
- Issue and write to r0, then read r0 -> data 0, valid 1, pend_err 0. With WB_BYPASS_PERF_EN: 3 stall cycles and 2 bypass cycles -> perf_stall 3, perf_bypass 2.

Source files
------------

// File: rtl/wb_bypass_pkg.sv
// Shared constants and types for the write-back bypass register file.
// Optional feature macro: WB_BYPASS_PERF_EN (performance counters).
package wb_bypass_pkg;

    localparam int DEF_DW     = 32;
    localparam int DEF_NREGS  = 32;
    localparam int DEF_AW     = 5;
    localparam int DEF_NRD    = 2;
    localparam int DEF_PEND_W = 2;

    // Architectural register that always reads as zero.
    localparam int ZERO_REG = 0;

    // One pending-write counter at the default width.
    typedef logic [DEF_PEND_W-1:0] pend_cnt_t;

endpackage

// File: rtl/wb_bypass_regfile_if.sv
// Bus between the ID/WB pipeline stages and the bypass register file.
// Optional feature macro: WB_BYPASS_PERF_EN adds the perf counter outputs.
interface wb_bypass_regfile_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
) ();

    logic [NRD*AW-1:0] rd_addr;
    logic [NRD*DW-1:0] rd_data;
    logic [NRD-1:0]    rd_valid;
    logic [NRD-1:0]    rd_en;
    logic              stall;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              pend_err;
`ifdef WB_BYPASS_PERF_EN
    logic [31:0]       perf_bypass;
    logic [31:0]       perf_stall;

    // Pipeline side: drives addresses, write-back and issue.
    modport master (
        output rd_addr, rd_en, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_valid, stall, pend_err, perf_bypass, perf_stall
    );

    // Register file side.
    modport slave (
        input  rd_addr, rd_en, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_valid, stall, pend_err, perf_bypass, perf_stall
    );
`else
    // Pipeline side: drives addresses, write-back and issue.
    modport master (
        output rd_addr, rd_en, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        input  rd_data, rd_valid, stall, pend_err
    );

    // Register file side.
    modport slave (
        input  rd_addr, rd_en, wr_en, wr_addr, wr_data, iss_en, iss_addr,
        output rd_data, rd_valid, stall, pend_err
    );
`endif

endinterface

// File: rtl/wb_bypass_rdport.sv
// One read port: write-through bypass mux and scoreboard-based valid flag.
module wb_bypass_rdport
    import wb_bypass_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int AW     = DEF_AW,
    parameter int PEND_W = DEF_PEND_W
) (
    input  logic [AW-1:0]     rdAddr,
    input  logic [DW-1:0]     arrayData,
    input  logic [PEND_W-1:0] pendCnt,
    input  logic              wrEn,
    input  logic [AW-1:0]     wrAddr,
    input  logic [DW-1:0]     wrData,
    output logic [DW-1:0]     rdData,
    output logic              rdValid,
    output logic              bypassHit
);

    logic isZero;

    // Forward the in-flight write-back, and call the data current when no
    // writes are outstanding or the last one is arriving right now.
    always_comb begin
        isZero    = (rdAddr == AW'(ZERO_REG));
        bypassHit = wrEn && (wrAddr == rdAddr) && !isZero;
        rdData    = '0;
        if (!isZero) begin
            rdData = bypassHit ? wrData : arrayData;
        end
        rdValid = isZero
               || (pendCnt == '0)
               || ((pendCnt == PEND_W'(1)) && bypassHit);
    end

endmodule

// File: rtl/wb_bypass_regfile.sv
// Register file with write-through bypass and a pending-write scoreboard
// that tells the ID stage when a source operand is not yet written back.
// Optional feature macro: WB_BYPASS_PERF_EN (bypass/stall cycle counters).
module wb_bypass_regfile
    import wb_bypass_pkg::*;
#(
    parameter int DW     = DEF_DW,
    parameter int NREGS  = DEF_NREGS,
    parameter int AW     = DEF_AW,
    parameter int NRD    = DEF_NRD,
    parameter int PEND_W = DEF_PEND_W
) (
    input logic               clk,
    input logic               reset_n,
    wb_bypass_regfile_if.slave bus
);

    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    logic [DW-1:0]          regArray [NREGS];
    logic [PEND_W-1:0]      pendCnt  [NREGS];
    logic                   pendErr;
    logic [NREGS-1:0]       incVec;
    logic [NREGS-1:0]       decVec;
    logic [NRD-1:0][DW-1:0] rdDataPacked;
    logic [NRD-1:0]         rdValidVec;
    logic [NRD-1:0]         bypassVec;

    // Register writes from the write-back stage; entry 0 is never written.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regArray[r] <= '0;
            end
        end else if (bus.wr_en && (bus.wr_addr != AW'(ZERO_REG))) begin
            regArray[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Decode which register is reserved at issue and which is released.
    always_comb begin
        incVec = '0;
        decVec = '0;
        if (bus.iss_en && (bus.iss_addr != AW'(ZERO_REG))) begin
            incVec[bus.iss_addr] = 1'b1;
        end
        if (bus.wr_en && (bus.wr_addr != AW'(ZERO_REG))) begin
            decVec[bus.wr_addr] = 1'b1;
        end
    end

    // Pending-write counters; out-of-range updates hold the count and set
    // the sticky error flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < NREGS; r++) begin
                pendCnt[r] <= '0;
            end
            pendErr <= 1'b0;
        end else begin
            for (int r = 1; r < NREGS; r++) begin
                if (incVec[r] && !decVec[r]) begin
                    if (pendCnt[r] == CNT_MAX) begin
                        pendErr <= 1'b1;
                    end else begin
                        pendCnt[r] <= pendCnt[r] + PEND_W'(1);
                    end
                end else if (decVec[r] && !incVec[r]) begin
                    if (pendCnt[r] == '0) begin
                        pendErr <= 1'b1;
                    end else begin
                        pendCnt[r] <= pendCnt[r] - PEND_W'(1);
                    end
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : gPort
        logic [AW-1:0] portAddr;
        assign portAddr = bus.rd_addr[i*AW +: AW];

        wb_bypass_rdport #(
            .DW     (DW),
            .AW     (AW),
            .PEND_W (PEND_W)
        ) uRdPort (
            .rdAddr    (portAddr),
            .arrayData (regArray[portAddr]),
            .pendCnt   (pendCnt[portAddr]),
            .wrEn      (bus.wr_en),
            .wrAddr    (bus.wr_addr),
            .wrData    (bus.wr_data),
            .rdData    (rdDataPacked[i]),
            .rdValid   (rdValidVec[i]),
            .bypassHit (bypassVec[i])
        );
    end

    assign bus.rd_data  = rdDataPacked;
    assign bus.rd_valid = rdValidVec;
    assign bus.stall    = |(bus.rd_en & ~rdValidVec);
    assign bus.pend_err = pendErr;

`ifdef WB_BYPASS_PERF_EN
    logic [31:0] perfBypass;
    logic [31:0] perfStall;

    // Saturating counts of bypassing cycles and stall cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perfBypass <= '0;
            perfStall  <= '0;
        end else begin
            if ((|(bus.rd_en & bypassVec)) && (perfBypass != 32'hFFFF_FFFF)) begin
                perfBypass <= perfBypass + 32'd1;
            end
            if (bus.stall && (perfStall != 32'hFFFF_FFFF)) begin
                perfStall <= perfStall + 32'd1;
            end
        end
    end

    assign bus.perf_bypass = perfBypass;
    assign bus.perf_stall  = perfStall;
`else
    logic unusedBypass;
    assign unusedBypass = ^bypassVec;
`endif

endmodule

// File: tb/tb_wb_bypass_regfile.sv
// Self-checking bench for wb_bypass_regfile: directed steps from the
// test plan followed by random traffic, all against a behavioural model.
// Optional feature macro: WB_BYPASS_PERF_EN (perf counters also checked).
module tb_wb_bypass_regfile;

    localparam int DW     = 32;
    localparam int AW     = 5;
    localparam int NRD    = 2;
    localparam int NREGS  = 32;
    localparam int PEND_W = 2;
    localparam int CNTMAX = (1 << PEND_W) - 1;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    wb_bypass_regfile_if #(.DW(DW), .AW(AW), .NRD(NRD)) bus ();

    wb_bypass_regfile #(
        .DW     (DW),
        .NREGS  (NREGS),
        .AW     (AW),
        .NRD    (NRD),
        .PEND_W (PEND_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [DW-1:0] mem [NREGS];
    int            pend [NREGS];
    bit            errModel;
    longint        perfBypassModel;
    longint        perfStallModel;
    int            assertCount = 0;
    int            failCount   = 0;

    function automatic int portAddr(int p);
        logic [NRD*AW-1:0] all;
        all = bus.rd_addr;
        return int'(all[p*AW +: AW]);
    endfunction

    function automatic bit writeHits(int p);
        int a;
        a = portAddr(p);
        return (a != 0) && (bus.wr_en === 1'b1) && (int'(bus.wr_addr) == a);
    endfunction

    function automatic logic [DW-1:0] expData(int p);
        int a;
        a = portAddr(p);
        if (a == 0) return '0;
        if (writeHits(p)) return bus.wr_data;
        return mem[a];
    endfunction

    function automatic logic expValid(int p);
        int a;
        a = portAddr(p);
        if (a == 0) return 1'b1;
        if (pend[a] == 0) return 1'b1;
        if (pend[a] == 1 && writeHits(p)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic expStall();
        logic s;
        s = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (bus.rd_en[p] && !expValid(p)) s = 1'b1;
        end
        return s;
    endfunction

    task automatic modelReset();
        for (int r = 0; r < NREGS; r++) begin
            mem[r]  = '0;
            pend[r] = 0;
        end
        errModel        = 1'b0;
        perfBypassModel = 0;
        perfStallModel  = 0;
    endtask

    task automatic modelClock();
        int  ia;
        int  wa;
        bit  inc;
        bit  dec;
        bit  anyBypass;
        anyBypass = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            if (bus.rd_en[p] && writeHits(p)) anyBypass = 1'b1;
        end
        if (anyBypass && perfBypassModel < 64'hFFFF_FFFF) perfBypassModel++;
        if (expStall() && perfStallModel < 64'hFFFF_FFFF) perfStallModel++;
        ia  = int'(bus.iss_addr);
        wa  = int'(bus.wr_addr);
        inc = bus.iss_en && ia != 0;
        dec = bus.wr_en && wa != 0;
        if (dec) mem[wa] = bus.wr_data;
        if (inc && dec && ia == wa) begin
            // reservation and release cancel out
        end else begin
            if (inc) begin
                if (pend[ia] == CNTMAX) errModel = 1'b1;
                else pend[ia]++;
            end
            if (dec) begin
                if (pend[wa] == 0) errModel = 1'b1;
                else pend[wa]--;
            end
        end
    endtask

    task automatic checkOutput(string tag);
        logic [DW-1:0] obsD;
        logic [DW-1:0] expD;
        logic          obsB;
        logic          expB;
        for (int p = 0; p < NRD; p++) begin
            obsD = bus.rd_data[p*DW +: DW];
            expD = expData(p);
            assertCount++;
            assert (obsD === expD) else begin
                failCount++;
                $error("FAIL %s rd_data[%0d] observed %h expected %h", tag, p, obsD, expD);
            end
            obsB = bus.rd_valid[p];
            expB = expValid(p);
            assertCount++;
            assert (obsB === expB) else begin
                failCount++;
                $error("FAIL %s rd_valid[%0d] observed %b expected %b", tag, p, obsB, expB);
            end
        end
        obsB = bus.stall;
        expB = expStall();
        assertCount++;
        assert (obsB === expB) else begin
            failCount++;
            $error("FAIL %s stall observed %b expected %b", tag, obsB, expB);
        end
        obsB = bus.pend_err;
        expB = errModel;
        assertCount++;
        assert (obsB === expB) else begin
            failCount++;
            $error("FAIL %s pend_err observed %b expected %b", tag, obsB, expB);
        end
`ifdef WB_BYPASS_PERF_EN
        assertCount++;
        assert (bus.perf_bypass === 32'(perfBypassModel)) else begin
            failCount++;
            $error("FAIL %s perf_bypass observed %0d expected %0d", tag, bus.perf_bypass, perfBypassModel);
        end
        assertCount++;
        assert (bus.perf_stall === 32'(perfStallModel)) else begin
            failCount++;
            $error("FAIL %s perf_stall observed %0d expected %0d", tag, bus.perf_stall, perfStallModel);
        end
`endif
    endtask

    task automatic applyStimulus(string tag, logic [AW-1:0] a0, logic [AW-1:0] a1,
                                 logic [NRD-1:0] en, logic we, logic [AW-1:0] wa,
                                 logic [DW-1:0] wd, logic ie, logic [AW-1:0] ia);
        bus.rd_addr  = {a1, a0};
        bus.rd_en    = en;
        bus.wr_en    = we;
        bus.wr_addr  = wa;
        bus.wr_data  = wd;
        bus.iss_en   = ie;
        bus.iss_addr = ia;
        #1;
        checkOutput(tag);
        @(posedge clk);
        modelClock();
        @(negedge clk);
    endtask

    task automatic doReset();
        reset_n      = 1'b0;
        bus.rd_addr  = {AW'(0), AW'(3)};
        bus.rd_en    = 2'b11;
        bus.wr_en    = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.iss_en   = 1'b0;
        bus.iss_addr = '0;
        #1;
        modelReset();
        checkOutput("in_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        $display("[TB] directed phase");
        doReset();
        applyStimulus("rd_after_reset", 3, 0, 2'b11, 0, 0, 0, 0, 0);

        applyStimulus("wr_r5_bypass", 5, 0, 2'b01, 1, 5, 32'hDEAD_BEEF, 0, 0);
        applyStimulus("rd_r5",        5, 0, 2'b01, 0, 0, 0, 0, 0);

        applyStimulus("iss_r7",       0, 0, 2'b00, 0, 0, 0, 1, 7);
        applyStimulus("rd_r7_pend_a", 7, 0, 2'b01, 0, 0, 0, 0, 0);
        applyStimulus("rd_r7_pend_b", 7, 0, 2'b01, 0, 0, 0, 0, 0);
        applyStimulus("wb_r7",        7, 0, 2'b01, 1, 7, 32'h1234, 0, 0);

        applyStimulus("iss_r9_a",     0, 0, 2'b00, 0, 0, 0, 1, 9);
        applyStimulus("iss_r9_b",     0, 0, 2'b00, 0, 0, 0, 1, 9);
        applyStimulus("wb_r9_first",  9, 0, 2'b01, 1, 9, 32'h11, 0, 0);
        applyStimulus("wb_r9_second", 9, 0, 2'b01, 1, 9, 32'h22, 0, 0);

        applyStimulus("iss_wr_r0",    0, 0, 2'b11, 1, 0, 32'hAAAA_5555, 1, 0);
        applyStimulus("rd_r0",        0, 0, 2'b11, 0, 0, 0, 0, 0);

        applyStimulus("iss_r4",       0, 0, 2'b00, 0, 0, 0, 1, 4);
        applyStimulus("iss_wb_r4",    4, 0, 2'b01, 1, 4, 32'h44, 1, 4);
        applyStimulus("rd_r4_held",   4, 5, 2'b11, 0, 0, 0, 0, 0);
        applyStimulus("wb_r4_clear",  0, 4, 2'b10, 1, 4, 32'h45, 0, 0);
        applyStimulus("wb_r6_under",  6, 0, 2'b01, 1, 6, 32'h66, 0, 0);
        applyStimulus("err_set",      6, 4, 2'b11, 0, 0, 0, 0, 0);
        applyStimulus("err_sticky",   0, 0, 2'b00, 0, 0, 0, 0, 0);

        $display("[TB] mid-operation reset and overflow");
        doReset();
        for (int k = 0; k < 4; k++) begin
            applyStimulus("iss_r10_ovf", 0, 10, 2'b10, 0, 0, 0, 1, 10);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus("wb_r10_drain", 0, 10, 2'b10, 1, 10, 32'(k + 32'h100), 0, 0);
        end
        applyStimulus("rd_r10_free", 0, 10, 2'b10, 0, 0, 0, 0, 0);

        $display("[TB] random phase");
        doReset();
        for (int k = 0; k < 400; k++) begin
            applyStimulus("random",
                          AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                          NRD'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          AW'($urandom_range(0, 7)), $urandom(),
                          1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
